sdram_write_ctrl: RTL and testbench
===================================

Name: sdram_write_ctrl

Overview:
Parametrised SDRAM write engine. Writes a job of NUM_ROWS full rows, starting at row 0 of bank BANK, as back-to-back bursts of BURST_LEN beats.
- Sits behind the command arbiter: requests the bus, issues ACT/WRITE/PRE, and streams data from a first-word-fall-through FIFO.
- Yields the bus to refresh at burst boundaries and resumes at the saved row/column.

Parameters:
ROW_W, 12, row address width (SDRAM A bus width)
COL_W, 9, column address width, COL_W <= ROW_W-2
DATA_W, 16, data width
BURST_LEN, 4, burst length, power of two, 1..8
NUM_ROWS, 2, rows per job, 1..2**ROW_W
T_RCD, 2, ACT-to-WRITE cycles, >=1
T_WR, 2, last-beat-to-PRE cycles, >=1
T_RP, 2, PRE-to-next-command cycles, >=1
BANK, 0, bank address driven for the whole job

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_trig  in  1  start job pulse; ignored unless IDLE
wr_en  in  1  arbiter grant, level
ref_req  in  1  refresh pending, level
wr_req  out  1  bus request
flag_wr_end  out  1  one-cycle pulse: bus released
wr_busy  out  1  job in progress (not IDLE)
wr_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}
wr_addr  out  ROW_W  SDRAM A bus
bank_addr  out  2  constant BANK
wr_din  in  DATA_W  FIFO head word
wr_data_rd  out  1  FIFO pop, one per beat
wr_data  out  DATA_W  write data to pads

Behaviour:
- Reset values: wr_cmd=NOP (0111), wr_addr=0, wr_req=0, flag_wr_end=0, wr_busy=0, wr_data_rd=0, wr_data=0. Row/column counters are 0 and state is IDLE.
- Commands: NOP 0111, ACT 0011, WRITE 0100, PRE 0010. WRITE drives A10=0 with the column in A[COL_W-1:0]. PRE drives A10=1 (all banks). ACT drives the row.
- All command, address and data outputs are registered. The command and its first data beat leave in the same cycle.
- IDLE: on wr_trig, clear row/col counters and go to REQ.
- REQ: wr_req=1 (combinational from state). When wr_en=1, go to ACT.
- ACT: lasts T_RCD cycles. ACT command in the first cycle, NOP after. Then go to WRITE.
- WRITE: beat counter 0..BURST_LEN-1.
  - Beat 0 issues WRITE at col_cnt; every beat pops the FIFO and drives wr_din.
  - At the last beat, col_cnt += BURST_LEN, wrapping to 0 at end of row.
  - At the last beat, leave WRITE when any of these holds: ref_req=1, end of row, or end of job. Otherwise continue the next burst with no gap.
  - ref_req never aborts a burst mid-way.
- PRE: T_WR NOP cycles, then the PRE command, then T_RP-1 NOP cycles. On exit, in priority order:
  1. Job done (last burst of row NUM_ROWS-1 written): pulse flag_wr_end, go to IDLE.
  2. ref_req latched: pulse flag_wr_end, go to REQ; resume at the saved row/col.
  3. Row end: row_cnt+1, go to ACT directly. The bus is held.
- ref_req is sampled at the last beat; a later assertion waits for the next boundary.
- wr_trig during a job: ignored. wr_en deassert outside REQ: ignored.
- Data underrun is not checked; the FIFO must hold BURST_LEN words before each burst.
- Async reset mid-job returns to IDLE immediately, with outputs at reset values and no PRE issued.

Optional Feature:
SDRAM_WR_PATTERN_EN.
- Defined: wr_din is ignored and wr_data_rd is held 0. wr_data is an internal DATA_W counter that starts at 1 on wr_trig and increments per beat; it is not reset on refresh resume.
- Undefined: FIFO data path as above.

Decomposition:
- Package sdram_pkg holds:
  - command encodings CMD_NOP/ACT/WRITE/PRE;
  - the state encoding IDLE/REQ/ACT/WRITE/PRE (one-hot, 5 bits);
  - the A10 bit index;
  - default timing constants, shared with the read and refresh blocks.
- One sub-module, sdram_wr_addr_gen, holds the row/col/beat counters. It outputs last_beat, row_end and job_end strobes.

Test Plan:
- COL_W=3, BURST_LEN=4, NUM_ROWS=1, grant immediate, no refresh -> exactly two WRITE commands, at col 0 and col 4, with 8 pops. Then PRE with A10=1 T_WR cycles after the last beat, one flag_wr_end pulse, IDLE.
- NUM_ROWS=2, same sizes -> ACT row0, 2 bursts, PRE, ACT row1 with no wr_req drop and no flag_wr_end, 2 bursts, PRE, then flag_wr_end.
- Raise ref_req at beat 1 of the col-0 burst -> burst completes (4 beats), PRE, flag_wr_end, REQ. After re-grant: ACT same row, WRITE at col 4.
- Hold wr_en=0 for 20 cycles in REQ -> wr_req stays 1 and wr_cmd stays NOP throughout.
- Assert rst_n=0 during the WRITE state -> all outputs go to reset values asynchronously. A new wr_trig after release restarts at row 0, col 0.
- With SDRAM_WR_PATTERN_EN, NUM_ROWS=1, COL_W=3 -> wr_data sequence 1..8 and wr_data_rd never asserted.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, write-engine state encoding,
// the A10 address bit and default timing used by the read/write/refresh blocks.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_REQ   = 5'b00010,
        ST_ACT   = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_PRE   = 5'b10000
    } wr_state_t;

    localparam int unsigned A10_BIT = 10;

    localparam int unsigned DEF_T_RCD = 2;
    localparam int unsigned DEF_T_WR  = 2;
    localparam int unsigned DEF_T_RP  = 2;

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// Row/column/beat counters for the SDRAM write engine, with last-beat,
// end-of-row and end-of-job strobes (all qualified by an active beat).
module sdram_wr_addr_gen #(
    parameter int unsigned ROW_W     = 12,
    parameter int unsigned COL_W     = 9,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned NUM_ROWS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             beat_en,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             beat_first,
    output logic             last_beat,
    output logic             row_end,
    output logic             job_end
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [BEAT_W-1:0] beat;
    logic [COL_W-1:0]  col_nxt;

    assign col_nxt    = col + COL_W'(BURST_LEN);
    assign beat_first = (beat == '0);
    assign last_beat  = beat_en && (beat == BEAT_W'(BURST_LEN - 1));
    assign row_end    = last_beat && (col_nxt == '0);
    assign job_end    = row_end && (row == ROW_W'(NUM_ROWS - 1));

    // Row advances together with the column wrap so the saved position always
    // points at the next burst to write, whether resuming via ACT or via REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            col  <= '0;
            beat <= '0;
        end else if (clr) begin
            row  <= '0;
            col  <= '0;
            beat <= '0;
        end else if (beat_en) begin
            if (last_beat) begin
                beat <= '0;
                col  <= col_nxt;
                if (row_end && !job_end) begin
                    row <= row + 1'b1;
                end
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_write_ctrl.sv
// SDRAM write engine: ACT/WRITE/PRE sequencing of whole-row jobs from a FWFT FIFO,
// yielding to refresh at burst boundaries. Optional macro SDRAM_WR_PATTERN_EN.
module sdram_write_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_W     = 12,
    parameter int unsigned COL_W     = 9,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned NUM_ROWS  = 2,
    parameter int unsigned T_RCD     = DEF_T_RCD,
    parameter int unsigned T_WR      = DEF_T_WR,
    parameter int unsigned T_RP      = DEF_T_RP,
    parameter int unsigned BANK      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_trig,
    input  logic              wr_en,
    input  logic              ref_req,
    output logic              wr_req,
    output logic              flag_wr_end,
    output logic              wr_busy,
    output logic [3:0]        wr_cmd,
    output logic [ROW_W-1:0]  wr_addr,
    output logic [1:0]        bank_addr,
    input  logic [DATA_W-1:0] wr_din,
    output logic              wr_data_rd,
    output logic [DATA_W-1:0] wr_data
);

    localparam int unsigned TMR_W = $clog2(T_RCD + T_WR + T_RP + 1);

    wr_state_t         state, state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [3:0]        cmd_nxt;
    logic [ROW_W-1:0]  addr_nxt;
    logic              flag_nxt;
    logic              beat_en;
    logic              job_clr;
    logic              ref_lat;
    logic              done_lat;
    logic [DATA_W-1:0] data_src;

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              beat_first;
    logic              last_beat;
    logic              row_end;
    logic              job_end;

    sdram_wr_addr_gen #(
        .ROW_W     (ROW_W),
        .COL_W     (COL_W),
        .BURST_LEN (BURST_LEN),
        .NUM_ROWS  (NUM_ROWS)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (job_clr),
        .beat_en    (beat_en),
        .row        (row),
        .col        (col),
        .beat_first (beat_first),
        .last_beat  (last_beat),
        .row_end    (row_end),
        .job_end    (job_end)
    );

    assign bank_addr = 2'(BANK);
    assign wr_busy   = (state != ST_IDLE);
    assign wr_req    = (state != ST_IDLE);

`ifdef SDRAM_WR_PATTERN_EN
    logic [DATA_W-1:0] pat;
    logic              unused_din;

    assign unused_din = ^wr_din;
    assign wr_data_rd = 1'b0;
    assign data_src   = pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat <= '0;
        end else if (job_clr) begin
            pat <= DATA_W'(1);
        end else if (beat_en) begin
            pat <= pat + 1'b1;
        end
    end
`else
    // FWFT pop is combinational so the head word is consumed on the same edge
    // that registers it onto wr_data.
    assign wr_data_rd = beat_en;
    assign data_src   = wr_din;
`endif

    always_comb begin
        state_nxt = state;
        cmd_nxt   = CMD_NOP;
        addr_nxt  = '0;
        flag_nxt  = 1'b0;
        beat_en   = 1'b0;
        job_clr   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wr_trig) begin
                    job_clr   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_en) begin
                    state_nxt = ST_ACT;
                end
            end
            ST_ACT: begin
                if (timer == '0) begin
                    cmd_nxt  = CMD_ACT;
                    addr_nxt = row;
                end
                if (timer == TMR_W'(T_RCD - 1)) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                beat_en = 1'b1;
                if (beat_first) begin
                    cmd_nxt               = CMD_WRITE;
                    addr_nxt[COL_W-1:0]   = col;
                end
                if (last_beat && (ref_req || row_end || job_end)) begin
                    state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                // PRE lands T_WR cycles after the last beat; exit leaves T_RP to the next command.
                if (timer == TMR_W'(T_WR - 1)) begin
                    cmd_nxt           = CMD_PRE;
                    addr_nxt[A10_BIT] = 1'b1;
                end
                if (timer == TMR_W'(T_WR + T_RP - 2)) begin
                    if (done_lat) begin
                        flag_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (ref_lat) begin
                        flag_nxt  = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_ACT;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            wr_cmd      <= CMD_NOP;
            wr_addr     <= '0;
            wr_data     <= '0;
            flag_wr_end <= 1'b0;
            ref_lat     <= 1'b0;
            done_lat    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_cmd      <= cmd_nxt;
            wr_addr     <= addr_nxt;
            flag_wr_end <= flag_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (state == ST_ACT || state == ST_PRE) begin
                timer <= timer + 1'b1;
            end
            if (beat_en) begin
                wr_data <= data_src;
            end
            if (job_clr) begin
                ref_lat  <= 1'b0;
                done_lat <= 1'b0;
            end else if (last_beat) begin
                ref_lat  <= ref_req;
                done_lat <= job_end;
            end
        end
    end

endmodule

// File: tb/tb_sdram_write_ctrl.sv
// Self-checking bench for sdram_write_ctrl: cycle table for a two-row job plus
// directed sequences for REQ stall, async reset mid-job and refresh yield/resume.
module tb_sdram_write_ctrl;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_trig;
    logic        wr_en;
    logic        ref_req;
    logic        wr_req;
    logic        flag_wr_end;
    logic        wr_busy;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  bank_addr;
    logic [15:0] wr_din;
    logic        wr_data_rd;
    logic [15:0] wr_data;

    int compared   = 0;
    int mismatched = 0;
    int fifo_idx   = 0;

    typedef struct {
        logic        trig;
        logic        en;
        logic        rf;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic        req;
        logic        busy;
        logic        flag;
        logic        rd;
        int          didx;
    } vec_t;

    vec_t tbl[$];

    sdram_write_ctrl #(
        .ROW_W     (12),
        .COL_W     (3),
        .DATA_W    (16),
        .BURST_LEN (4),
        .NUM_ROWS  (2),
        .T_RCD     (2),
        .T_WR      (2),
        .T_RP      (2),
        .BANK      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_trig     (wr_trig),
        .wr_en       (wr_en),
        .ref_req     (ref_req),
        .wr_req      (wr_req),
        .flag_wr_end (flag_wr_end),
        .wr_busy     (wr_busy),
        .wr_cmd      (wr_cmd),
        .wr_addr     (wr_addr),
        .bank_addr   (bank_addr),
        .wr_din      (wr_din),
        .wr_data_rd  (wr_data_rd),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: head word is A000 + number of words popped so far.
    always @(posedge clk) begin
        if (wr_data_rd) fifo_idx <= fifo_idx + 1;
    end
    assign wr_din = 16'hA000 + 16'(fifo_idx);

    function automatic logic [15:0] exp_word(input int base, input int k);
`ifdef SDRAM_WR_PATTERN_EN
        return 16'(k + 1);
`else
        return 16'hA000 + 16'(base + k);
`endif
    endfunction

    function automatic logic exp_rd(input logic rd);
`ifdef SDRAM_WR_PATTERN_EN
        return 1'b0 & rd;
`else
        return rd;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_cmd(input logic [3:0] c, input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (wr_cmd !== c && n < 20);
        check({nm, "_seen"}, 32'(wr_cmd), 32'(c));
    endtask

    task automatic wait_flag(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (flag_wr_end !== 1'b1 && n < 80);
        check({nm, "_flag"}, 32'(flag_wr_end), 32'd1);
    endtask

    task automatic add(input logic tr, input logic en, input logic rf, input logic [3:0] c,
                       input logic [11:0] a, input logic rq, input logic bz, input logic fl,
                       input logic rd, input int di);
        vec_t v;
        v.trig = tr; v.en = en; v.rf = rf; v.cmd = c; v.addr = a;
        v.req = rq; v.busy = bz; v.flag = fl; v.rd = rd; v.didx = di;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Two-row job, outputs as seen #1 after each edge; trig mid-job and
        // wr_en drop after grant must both be ignored.
        add(1,0,0, NOP,12'h000, 1,1,0,0,-1);
        add(0,1,0, NOP,12'h000, 1,1,0,0,-1);
        add(0,1,0, ACT,12'h000, 1,1,0,0,-1);
        add(0,0,0, NOP,12'h000, 1,1,0,1,-1);
        add(0,0,0, WRC,12'h000, 1,1,0,1, 0);
        add(0,0,0, NOP,12'h000, 1,1,0,1, 1);
        add(0,0,0, NOP,12'h000, 1,1,0,1, 2);
        add(0,0,0, NOP,12'h000, 1,1,0,1, 3);
        add(0,0,0, WRC,12'h004, 1,1,0,1, 4);
        add(1,0,0, NOP,12'h000, 1,1,0,1, 5);
        add(0,0,0, NOP,12'h000, 1,1,0,1, 6);
        add(0,0,0, NOP,12'h000, 1,1,0,0, 7);
        add(0,0,0, NOP,12'h000, 1,1,0,0,-1);
        add(0,0,0, PRE,12'h400, 1,1,0,0,-1);
        add(0,0,0, NOP,12'h000, 1,1,0,0,-1);
        add(0,0,0, ACT,12'h001, 1,1,0,0,-1);
        add(0,0,0, NOP,12'h000, 1,1,0,1,-1);
        add(0,0,0, WRC,12'h000, 1,1,0,1, 8);
        add(0,0,0, NOP,12'h000, 1,1,0,1, 9);
        add(0,0,0, NOP,12'h000, 1,1,0,1,10);
        add(1,0,0, NOP,12'h000, 1,1,0,1,11);
        add(0,0,0, WRC,12'h004, 1,1,0,1,12);
        add(0,0,0, NOP,12'h000, 1,1,0,1,13);
        add(0,0,0, NOP,12'h000, 1,1,0,1,14);
        add(0,0,0, NOP,12'h000, 1,1,0,0,15);
        add(0,0,0, NOP,12'h000, 1,1,0,0,-1);
        add(0,0,0, PRE,12'h400, 1,1,0,0,-1);
        add(0,0,0, NOP,12'h000, 0,0,1,0,-1);
        add(0,0,0, NOP,12'h000, 0,0,0,0,-1);

        rst_n = 1'b0; wr_trig = 1'b0; wr_en = 1'b0; ref_req = 1'b0;
        step();
        step();
        check("rst_cmd",  32'(wr_cmd), 32'(NOP));
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_req",  32'(wr_req), 32'd0);
        check("rst_flag", 32'(flag_wr_end), 32'd0);
        check("rst_busy", 32'(wr_busy), 32'd0);
        check("rst_rd",   32'(wr_data_rd), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("bank",     32'(bank_addr), 32'd1);
        rst_n = 1'b1;

        base = fifo_idx;
        for (int i = 0; i < tbl.size(); i++) begin
            wr_trig = tbl[i].trig; wr_en = tbl[i].en; ref_req = tbl[i].rf;
            step();
            check($sformatf("v%0d_cmd", i),  32'(wr_cmd), 32'(tbl[i].cmd));
            check($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
            check($sformatf("v%0d_req", i),  32'(wr_req), 32'(tbl[i].req));
            check($sformatf("v%0d_busy", i), 32'(wr_busy), 32'(tbl[i].busy));
            check($sformatf("v%0d_flag", i), 32'(flag_wr_end), 32'(tbl[i].flag));
            check($sformatf("v%0d_rd", i),   32'(wr_data_rd), 32'(exp_rd(tbl[i].rd)));
            if (tbl[i].didx >= 0)
                check($sformatf("v%0d_data", i), 32'(wr_data), 32'(exp_word(base, tbl[i].didx)));
        end
        wr_trig = 1'b0; wr_en = 1'b0;

        // Grant withheld for 20 cycles in REQ.
        wr_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("stall%0d_req", i), 32'(wr_req), 32'd1);
            check($sformatf("stall%0d_cmd", i), 32'(wr_cmd), 32'(NOP));
        end

        // Async reset inside the row-1 col-4 burst, then restart from row 0 col 0.
        wr_en = 1'b1;
        wait_cmd(ACT, "b_act0");
        check("b_act0_row", 32'(wr_addr), 32'd0);
        wait_cmd(WRC, "b_wr0");
        wait_cmd(WRC, "b_wr1");
        check("b_wr1_col", 32'(wr_addr), 32'd4);
        wait_cmd(ACT, "b_act1");
        check("b_act1_row", 32'(wr_addr), 32'd1);
        wait_cmd(WRC, "b_wr2");
        wait_cmd(WRC, "b_wr3");
        check("b_wr3_col", 32'(wr_addr), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmd",  32'(wr_cmd), 32'(NOP));
        check("arst_addr", 32'(wr_addr), 32'd0);
        check("arst_req",  32'(wr_req), 32'd0);
        check("arst_busy", 32'(wr_busy), 32'd0);
        check("arst_rd",   32'(wr_data_rd), 32'd0);
        check("arst_data", 32'(wr_data), 32'd0);
        step();
        rst_n = 1'b1;
        base = fifo_idx;
        wr_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        wait_cmd(ACT, "r_act");
        check("r_act_row", 32'(wr_addr), 32'd0);
        wait_cmd(WRC, "r_wr");
        check("r_wr_col",  32'(wr_addr), 32'd0);
        check("r_wr_data", 32'(wr_data), 32'(exp_word(base, 0)));
        wait_flag("r_end");
        check("r_end_busy", 32'(wr_busy), 32'd0);

        // Refresh raised at beat 1 of the col-0 burst: burst completes, yield, resume at col 4.
        base = fifo_idx;
        wr_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        wait_cmd(ACT, "f_act");
        check("f_act_row", 32'(wr_addr), 32'd0);
        wait_cmd(WRC, "f_wr0");
        check("f_wr0_col", 32'(wr_addr), 32'd0);
        ref_req = 1'b1;
        wr_en   = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("f_s%0d_cmd", k), 32'(wr_cmd), 32'((k == 5) ? PRE : NOP));
            if (k <= 3)
                check($sformatf("f_s%0d_data", k), 32'(wr_data), 32'(exp_word(base, k)));
            if (k == 2)
                check("f_s2_rd", 32'(wr_data_rd), 32'(exp_rd(1'b1)));
            if (k == 3)
                check("f_s3_rd", 32'(wr_data_rd), 32'd0);
        end
        check("f_pre_a10", 32'(wr_addr), 32'h400);
        ref_req = 1'b0;
        step();
        check("f_yield_flag", 32'(flag_wr_end), 32'd1);
        check("f_yield_req",  32'(wr_req), 32'd1);
        check("f_yield_busy", 32'(wr_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("f_wait%0d_flag", i), 32'(flag_wr_end), 32'd0);
            check($sformatf("f_wait%0d_cmd", i),  32'(wr_cmd), 32'(NOP));
        end
        wr_en = 1'b1;
        wait_cmd(ACT, "f_react");
        check("f_react_row", 32'(wr_addr), 32'd0);
        wait_cmd(WRC, "f_wr1");
        check("f_wr1_col",  32'(wr_addr), 32'd4);
        check("f_wr1_data", 32'(wr_data), 32'(exp_word(base, 4)));
        wait_flag("f_end");
        check("f_end_busy", 32'(wr_busy), 32'd0);
        step();
        check("f_end_pulse", 32'(flag_wr_end), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
